// File: rtl/pe_array_sequencer.sv
// Sequencer for a PE array: streams K*K weights, then cfg_len activations, onto the TSV channel.
// It then drains the array and reports the job length in cycles.
module pe_array_sequencer #(
  parameter int DW = 8,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [4:0]    cfg_kernelsize,
  input  logic [7:0]    cfg_sizex,
  input  logic [7:0]    cfg_sizey,
  input  logic [CW-1:0] cfg_len,
  input  logic [DW-1:0] w_data,
  input  logic          w_valid,
  output logic          w_ready,
  input  logic [DW-1:0] a_data,
  input  logic          a_valid,
  output logic          a_ready,
  output logic [DW-1:0] tsv_out,
  output logic          tsv_vld,
  output logic          tsv_sel,
  output logic          workstate,
  output logic          busy,
  output logic          done,
  output logic          cfg_err,
  output logic [CW-1:0] cycle_count
);

  // state   | meaning
  // IDLE    | waiting for start
  // LOAD_W  | accepting K*K weights
  // COMPUTE | accepting cfg_len activations
  // DRAIN   | sizex+sizey+K cycles for the array to flush
  // DONE    | one-cycle completion, cycle_count updated
  typedef enum logic [2:0] {IDLE, LOAD_W, COMPUTE, DRAIN, DONE} state_t;

  state_t        state_q, state_d;
  logic [3:0]    k_q, k_d;
  logic [7:0]    sx_q, sx_d, sy_q, sy_d;
  logic [CW-1:0] len_q, len_d;
  logic [7:0]    wcnt_q, wcnt_d;
  logic [CW-1:0] acnt_q, acnt_d;
  logic [9:0]    drain_q, drain_d;
  logic [CW-1:0] perf_q, perf_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [DW-1:0] tsv_out_q, tsv_out_d;
  logic          tsv_vld_q, tsv_vld_d, tsv_sel_q, tsv_sel_d;
  logic          cfg_err_q, cfg_err_d;
  logic          cfg_legal, w_hs, a_hs;
  logic [7:0]    kk;

  assign w_ready     = (state_q == LOAD_W);
  assign a_ready     = (state_q == COMPUTE);
  assign workstate   = (state_q == LOAD_W) || (state_q == COMPUTE) || (state_q == DRAIN);
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign tsv_out     = tsv_out_q;
  assign tsv_vld     = tsv_vld_q;
  assign tsv_sel     = tsv_sel_q;
  assign cfg_err     = cfg_err_q;
  assign cycle_count = cyc_q;

  assign w_hs = w_valid && w_ready;
  assign a_hs = a_valid && a_ready;
  assign kk   = {4'b0, k_q} * {4'b0, k_q};

  assign cfg_legal = (cfg_kernelsize != 5'd0) && (cfg_kernelsize <= 5'd15) &&
                     (cfg_sizex >= {3'b0, cfg_kernelsize}) &&
                     (cfg_sizey >= {3'b0, cfg_kernelsize}) && (cfg_len != '0);

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    sx_d      = sx_q;
    sy_d      = sy_q;
    len_d     = len_q;
    wcnt_d    = wcnt_q;
    acnt_d    = acnt_q;
    drain_d   = drain_q;
    perf_d    = perf_q;
    cyc_d     = cyc_q;
    tsv_out_d = tsv_out_q;
    tsv_sel_d = tsv_sel_q;
    tsv_vld_d = 1'b0;
    cfg_err_d = 1'b0;

    if (w_hs) begin
      tsv_out_d = w_data;
      tsv_sel_d = 1'b0;
      tsv_vld_d = 1'b1;
    end else if (a_hs) begin
      tsv_out_d = a_data;
      tsv_sel_d = 1'b1;
      tsv_vld_d = 1'b1;
    end

    if (workstate && (perf_q != '1)) perf_d = perf_q + CW'(1);

    case (state_q)
      IDLE: begin
        if (!abort && start) begin
          if (cfg_legal) begin
            k_d     = cfg_kernelsize[3:0];
            sx_d    = cfg_sizex;
            sy_d    = cfg_sizey;
            len_d   = cfg_len;
            wcnt_d  = '0;
            acnt_d  = '0;
            perf_d  = '0;
            state_d = LOAD_W;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      LOAD_W: begin
        if (w_hs) begin
          wcnt_d = wcnt_q + 8'd1;
          if (wcnt_q + 8'd1 == kk) state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        if (a_hs) begin
          acnt_d = acnt_q + CW'(1);
          if (acnt_q + CW'(1) == len_q) begin
            state_d = DRAIN;
            drain_d = {2'b0, sx_q} + {2'b0, sy_q} + {6'b0, k_q};
          end
        end
      end
      DRAIN: begin
        if (drain_q == 10'd1) begin
          drain_d = '0;
          state_d = DONE;
        end else begin
          drain_d = drain_q - 10'd1;
        end
      end
      DONE: begin
        cyc_d   = perf_q;
        wcnt_d  = '0;
        acnt_d  = '0;
        perf_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over any transition; the beat accepted this cycle is still forwarded above.
    if (abort && workstate) begin
      state_d = IDLE;
      wcnt_d  = '0;
      acnt_d  = '0;
      drain_d = '0;
      perf_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      k_q       <= '0;
      sx_q      <= '0;
      sy_q      <= '0;
      len_q     <= '0;
      wcnt_q    <= '0;
      acnt_q    <= '0;
      drain_q   <= '0;
      perf_q    <= '0;
      cyc_q     <= '0;
      tsv_out_q <= '0;
      tsv_vld_q <= 1'b0;
      tsv_sel_q <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      sx_q      <= sx_d;
      sy_q      <= sy_d;
      len_q     <= len_d;
      wcnt_q    <= wcnt_d;
      acnt_q    <= acnt_d;
      drain_q   <= drain_d;
      perf_q    <= perf_d;
      cyc_q     <= cyc_d;
      tsv_out_q <= tsv_out_d;
      tsv_vld_q <= tsv_vld_d;
      tsv_sel_q <= tsv_sel_d;
      cfg_err_q <= cfg_err_d;
    end
  end

endmodule
